rb_scheduler: RTL and testbench

Schedules core-to-Jetson readback traffic. Up to N_CH status/sensor modules raise single-cycle report pulses with a data word. The block latches each word in a per-channel holding register and grants the single SPIJetson write port one channel per cycle, using round-robin. It replaces the plain pulse arbiter between the module bank and the SPIJetson `wr_en`/`wr_din` inputs, and adds urgent-channel priority, drop detection and the Jetson "urgent" GPIO indication.

---
 rtl/yabot_pkg.sv | 36 +++
 rtl/rb_scheduler_rr_pick.sv | 53 +++++
 rtl/rb_scheduler.sv | 159 +++++++++++++++
 tb/tb_rb_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yabot_pkg.sv
// ============================================================================
// Module      : yabot_pkg
// Description : Shared constants for the readback path. Holds the readback
//               word/select widths and the fixed channel numbering that the
//               top level and the Jetson driver both use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package yabot_pkg;

  // Readback word: 24 data bits plus 4 control bits
  localparam int RB_DW    = 28;
  // Channel-select field width on the SPIJetson side
  localparam int RB_SEL_W = 4;

  // Channel numbering shared with the Jetson driver
  localparam int RB_CH_STATUS    = 0;
  localparam int RB_CH_SONAR     = 1;
  localparam int RB_CH_MOTOR     = 2;
  localparam int RB_CH_ADC       = 3;
  localparam int RB_CH_RADIO     = 4;
  localparam int RB_CH_REMOTECTL = 5;
  localparam int RB_N_CH         = 6;

  typedef logic [RB_SEL_W-1:0] rb_sel_t;

  // Next channel index, wrapping at n by explicit compare rather than by
  // power-of-two overflow, since n is generally not a power of two.
  function automatic rb_sel_t rb_next_idx(input rb_sel_t idx, input int n);
    return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rb_scheduler_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating-priority encoder. Scans req_vec
//               starting at base, wrapping modulo N, and reports the first
//               set bit found.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import yabot_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0] req_vec,
  input  rb_sel_t      base,
  output logic         found,
  output rb_sel_t      idx
);

  // One extra bit so base + offset cannot overflow before the wrap compare
  localparam int CW = RB_SEL_W + 1;

  logic [CW-1:0] cand;
  logic          hit;

  // Walk candidates base, base+1, ... (mod N); the first pending one wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, base} + CW'(k);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      hit = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (cand == CW'(i)) begin
          hit = req_vec[i];
        end
      end
      if (!found && hit) begin
        found = 1'b1;
        idx   = cand[RB_SEL_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rb_scheduler.sv
// ============================================================================
// Module      : rb_scheduler
// Description : Readback scheduler feeding the SPIJetson write port. Latches
//               per-channel report words, grants one channel per cycle in
//               round-robin order, flags dropped reports and drives the
//               Jetson urgent indication.
//               Build option RB_URGENT_PRIO_EN: urgent channels are granted
//               ahead of non-urgent ones (round-robin within each class).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rb_scheduler
  import yabot_pkg::*;
#(
  parameter int N_CH = 6,
  parameter int DW   = RB_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*DW-1:0] bus_in,
  output logic [N_CH-1:0]    busy,
  input  logic               out_rdy,
  output logic               out_stb,
  output logic [DW-1:0]      out_data,
  output logic [3:0]         out_sel,
  input  logic [N_CH-1:0]    urgent_mask,
  output logic               urgent,
  output logic [N_CH-1:0]    drop,
  input  logic               drop_clr
);

  logic [N_CH-1:0] pend_q, pend_d;
  logic [DW-1:0]   hold_q [N_CH];
  logic [DW-1:0]   hold_d [N_CH];
  rb_sel_t         last_grant_q, last_grant_d;
  logic            out_stb_q, out_stb_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  rb_sel_t         out_sel_q, out_sel_d;
  logic            urgent_q, urgent_d;
  logic [N_CH-1:0] drop_q, drop_d;

  rb_sel_t         base;
  logic            all_found;
  rb_sel_t         all_idx;
  logic            pick_found;
  rb_sel_t         pick_idx;
  logic            grant;

  // Search begins one past the most recent grant
  assign base = rb_next_idx(last_grant_q, N_CH);

  rr_pick #(.N(N_CH)) u_pick_all (
    .req_vec (pend_q),
    .base    (base),
    .found   (all_found),
    .idx     (all_idx)
  );

`ifdef RB_URGENT_PRIO_EN
  logic [N_CH-1:0] urg_req;
  logic            urg_found;
  rb_sel_t         urg_idx;

  assign urg_req = pend_q & urgent_mask;

  rr_pick #(.N(N_CH)) u_pick_urg (
    .req_vec (urg_req),
    .base    (base),
    .found   (urg_found),
    .idx     (urg_idx)
  );

  // Urgent class takes precedence; both classes share one rotation pointer
  assign pick_found = urg_found | all_found;
  assign pick_idx   = urg_found ? urg_idx : all_idx;
`else
  assign pick_found = all_found;
  assign pick_idx   = all_idx;
`endif

  assign grant = out_rdy & pick_found;

  // Next-state: capture/drop per channel, then apply the grant
  always_comb begin
    pend_d       = pend_q;
    hold_d       = hold_q;
    last_grant_d = last_grant_q;
    out_stb_d    = 1'b0;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    // Clear first so a same-cycle drop event below wins
    drop_d       = drop_q & ~{N_CH{drop_clr}};

    for (int i = 0; i < N_CH; i++) begin
      if (req[i]) begin
        if (pend_q[i]) begin
          drop_d[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          hold_d[i] = bus_in[i*DW +: DW];
        end
      end
    end

    // A granted channel was pending, so it cannot also have captured above;
    // clearing after capture means the grant's clear always wins.
    if (grant) begin
      out_stb_d    = 1'b1;
      out_sel_d    = pick_idx;
      last_grant_d = pick_idx;
      for (int i = 0; i < N_CH; i++) begin
        if (pick_idx == rb_sel_t'(i)) begin
          out_data_d = hold_q[i];
          pend_d[i]  = 1'b0;
        end
      end
    end

    // Aligned with busy: reflects the pending set after this edge
    urgent_d = |(pend_d & urgent_mask);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_q[i] <= '0;
      end
      last_grant_q <= rb_sel_t'(N_CH - 1);
      out_stb_q    <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      urgent_q     <= 1'b0;
      drop_q       <= '0;
    end else begin
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      last_grant_q <= last_grant_d;
      out_stb_q    <= out_stb_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      urgent_q     <= urgent_d;
      drop_q       <= drop_d;
    end
  end

  assign busy     = pend_q;
  assign out_stb  = out_stb_q;
  assign out_data = out_data_q;
  assign out_sel  = out_sel_q;
  assign urgent   = urgent_q;
  assign drop     = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_rb_scheduler.sv
// ============================================================================
// Module      : tb_rb_scheduler
// Description : Directed self-checking bench for rb_scheduler. Expected
//               grants are queued when reports are driven and checked in
//               order as the write strobes appear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rb_scheduler;
  import yabot_pkg::*;

  localparam int N_CH = 6;
  localparam int DW   = RB_DW;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_CH-1:0]    req;
  logic [N_CH*DW-1:0] bus_in;
  logic [N_CH-1:0]    busy;
  logic               out_rdy;
  logic               out_stb;
  logic [DW-1:0]      out_data;
  logic [3:0]         out_sel;
  logic [N_CH-1:0]    urgent_mask;
  logic               urgent;
  logic [N_CH-1:0]    drop;
  logic               drop_clr;

  typedef struct packed {
    logic [3:0]    sel;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  rb_scheduler #(.N_CH(N_CH), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .bus_in      (bus_in),
    .busy        (busy),
    .out_rdy     (out_rdy),
    .out_stb     (out_stb),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .urgent_mask (urgent_mask),
    .urgent      (urgent),
    .drop        (drop),
    .drop_clr    (drop_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int ch, input logic [DW-1:0] data);
    req[ch]              = 1'b1;
    bus_in[ch*DW +: DW]  = data;
  endtask

  task automatic expect_grant(input int ch, input logic [DW-1:0] data);
    exp_q.push_back({4'(ch), data});
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_stb) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_stb", {31'b0, out_stb}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stb_sel", {28'b0, out_sel}, {28'b0, e.sel});
        chk("stb_data", {4'b0, out_data}, {4'b0, e.data});
      end
    end
  end

  initial begin
    int   stbs;
    logic urg_after_first;

    rst_n       = 1'b0;
    req         = '0;
    bus_in      = '0;
    out_rdy     = 1'b1;
    urgent_mask = 6'b010000;
    drop_clr    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",     {26'b0, busy}, 32'd0);
    chk("rst_out_stb",  {31'b0, out_stb}, 32'd0);
    chk("rst_out_data", {4'b0, out_data}, 32'd0);
    chk("rst_out_sel",  {28'b0, out_sel}, 32'd0);
    chk("rst_urgent",   {31'b0, urgent}, 32'd0);
    chk("rst_drop",     {26'b0, drop}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_no_stb", {31'b0, out_stb}, 32'd0);

    // Simultaneous reports on 0, 3, 5 drain in order 0, 3, 5
    post(0, 28'h0A0A0A0); expect_grant(0, 28'h0A0A0A0);
    post(3, 28'h3B3B3B3); expect_grant(3, 28'h3B3B3B3);
    post(5, 28'h5C5C5C5); expect_grant(5, 28'h5C5C5C5);
    tick();
    req = '0;
    chk("rr_busy", {26'b0, busy}, 32'b101001);
    chk("rr_no_stb_yet", {31'b0, out_stb}, 32'd0);
    tick(); chk("rr_stb0", {31'b0, out_stb}, 32'd1);
    tick(); chk("rr_stb1", {31'b0, out_stb}, 32'd1);
    tick(); chk("rr_stb2", {31'b0, out_stb}, 32'd1);
    // Lone req[0] after channel 5
    post(0, 28'h0D0D0D0); expect_grant(0, 28'h0D0D0D0);
    tick();
    req = '0;
    chk("rr_gap", {31'b0, out_stb}, 32'd0);
    tick(); chk("rr_wrap_stb", {31'b0, out_stb}, 32'd1);
    tick();

    // Backpressure: nothing granted while out_rdy is low
    out_rdy = 1'b0;
    post(1, 28'h1111111);
    post(4, 28'h4444444);
    tick();
    req  = '0;
    stbs = 0;
    repeat (10) begin
      tick();
      if (out_stb) stbs++;
    end
    chk("bp_no_stb", stbs, 32'd0);
    chk("bp_busy", {26'b0, busy}, 32'b010010);
    expect_grant(1, 28'h1111111);
    expect_grant(4, 28'h4444444);
    out_rdy = 1'b1;
    tick(); tick(); tick();
    chk("bp_drained", {26'b0, busy}, 32'd0);

    // Latency of a single report
    post(2, 28'h1234567); expect_grant(2, 28'h1234567);
    tick();
    req = '0;
    chk("lat_busy", {26'b0, busy}, 32'b000100);
    chk("lat_no_stb", {31'b0, out_stb}, 32'd0);
    tick();
    chk("lat_stb", {31'b0, out_stb}, 32'd1);
    chk("lat_sel", {28'b0, out_sel}, 32'd2);
    tick();
    chk("lat_busy_clr", {26'b0, busy}, 32'd0);
    chk("lat_stb_clr", {31'b0, out_stb}, 32'd0);

    // Drop on a busy channel; first word survives
    out_rdy = 1'b0;
    post(1, 28'hAAAAAAA);
    tick();
    post(1, 28'hBBBBBBB);
    tick();
    req = '0;
    chk("drop_set", {26'b0, drop}, 32'b000010);
    chk("drop_busy", {26'b0, busy}, 32'b000010);
    expect_grant(1, 28'hAAAAAAA);
    out_rdy = 1'b1;
    tick(); tick();
    chk("drop_sticky", {26'b0, drop}, 32'b000010);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("drop_clr", {26'b0, drop}, 32'd0);

    // Clear coinciding with a new drop: set wins
    out_rdy = 1'b0;
    post(1, 28'hCCCCCCC);
    tick();
    post(1, 28'hDDDDDDD);
    drop_clr = 1'b1;
    tick();
    req      = '0;
    drop_clr = 1'b0;
    chk("drop_set_wins", {26'b0, drop}, 32'b000010);
    expect_grant(1, 28'hCCCCCCC);
    out_rdy = 1'b1;
    tick(); tick();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;

    // Report arriving in the cycle its channel is granted
    post(3, 28'hEEEEEEE); expect_grant(3, 28'hEEEEEEE);
    tick();
    post(3, 28'hFFFFFFF);
    tick();
    req = '0;
    chk("gr_req_stb", {31'b0, out_stb}, 32'd1);
    chk("gr_req_busy", {26'b0, busy}, 32'd0);
    chk("gr_req_drop", {26'b0, drop}, 32'b001000);
    tick();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;

    // Move the rotation pointer to channel 5
    post(5, 28'h5555555); expect_grant(5, 28'h5555555);
    tick();
    req = '0;
    tick(); tick();

    // Urgent indication and (optionally) urgent priority
    out_rdy = 1'b0;
    post(0, 28'h0000AAA);
    post(4, 28'h4444AAA);
    tick();
    req = '0;
    chk("urg_pending", {31'b0, urgent}, 32'd1);
`ifdef RB_URGENT_PRIO_EN
    expect_grant(4, 28'h4444AAA);
    expect_grant(0, 28'h0000AAA);
    urg_after_first = 1'b0;
`else
    expect_grant(0, 28'h0000AAA);
    expect_grant(4, 28'h4444AAA);
    urg_after_first = 1'b1;
`endif
    out_rdy = 1'b1;
    tick();
    chk("urg_after_first", {31'b0, urgent}, {31'b0, urg_after_first});
    tick();
    chk("urg_after_both", {31'b0, urgent}, 32'd0);
    tick();

    // Asynchronous reset in the middle of a grant
    post(1, 28'h1010101);
    post(2, 28'h2020202);
    post(3, 28'h3030303);
    tick();
    req = '0;
    tick();
    chk("pre_rst_stb", {31'b0, out_stb}, 32'd1);
    chk("pre_rst_sel", {28'b0, out_sel}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",     {26'b0, busy}, 32'd0);
    chk("arst_out_stb",  {31'b0, out_stb}, 32'd0);
    chk("arst_out_sel",  {28'b0, out_sel}, 32'd0);
    chk("arst_out_data", {4'b0, out_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    stbs  = 0;
    repeat (3) begin
      tick();
      if (out_stb) stbs++;
    end
    chk("post_rst_no_stb", stbs, 32'd0);
    post(0, 28'h0F0F0F0); expect_grant(0, 28'h0F0F0F0);
    tick();
    req = '0;
    tick();
    chk("post_rst_stb", {31'b0, out_stb}, 32'd1);
    chk("post_rst_sel", {28'b0, out_sel}, 32'd0);
    tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
